hyper_mem_bist: RTL and testbench

- Synthesizable built-in self-test engine that replaces the random AXI master as the memory stress source.
- Sits in front of the HyperBus controller's memory-side request port, or behind an AXI-to-mem bridge.
- Writes a parametrised data pattern over a programmable address window, reads it back with pipelined outstanding reads, and compares in order.
- Reports error count, first failing address and a done/busy status.

---
 rtl/hyper_mem_bist.sv | 250 +++++++++++++++++++++++++
 tb/tb_hyper_mem_bist.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mem_bist.sv
// Memory BIST engine: writes a pattern over an address window, reads it back with pipelined
// outstanding reads and compares in order. Optional first-error capture: HYPER_MEM_BIST_ERR_LOG_EN.
module hyper_mem_bist #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = 16,
  parameter logic [31:0] Seed           = 32'h0000_ACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             mode_i,
  input  logic [1:0]             pattern_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [CntWidth-1:0]    num_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CntWidth-1:0]    err_cnt_o,
  output logic [AddrWidth-1:0]   first_err_addr_o,
  output logic [DataWidth-1:0]   first_err_rdata_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned ByteW = DataWidth / 8;
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam logic [31:0] SeedInit = (Seed == 32'd0) ? 32'd1 : Seed;
  localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(ByteW);
  localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(ByteW - 1));
  localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WRITE, S_READ, S_DRAIN, S_DONE, S_ABORT
  } state_t;

  state_t                 state_reg, state_next;
  logic                   abort_pend_reg, abort_pend_next;
  logic [1:0]             mode_reg, pattern_reg;
  logic [AddrWidth-1:0]   base_reg, addr_reg, rsp_addr_reg;
  logic [CntWidth-1:0]    num_words_reg, idx_reg, err_cnt_reg;
  logic                   rsp_odd_reg;
  logic [31:0]            wr_lfsr_reg, rsp_lfsr_reg;
  logic [OutW-1:0]        outstanding_reg;
  logic                   cmp_valid_reg;
  logic [DataWidth-1:0]   cmp_rdata_reg, cmp_exp_reg;

  logic start_acc, gnt_fire, rd_gnt, rsp_fire, cmp_fire, last_word, cmp_mismatch;
  logic [DataWidth-1:0] wr_addr_ext, rsp_addr_ext, wr_lfsr_rep, rsp_lfsr_rep;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DataWidth-1:0] pattern_word(input logic [1:0] pat,
                                                        input logic [DataWidth-1:0] a_ext,
                                                        input logic [DataWidth-1:0] l_rep,
                                                        input logic odd);
    logic [DataWidth-1:0] w;
    case (pat)
      2'd0:    w = a_ext;
      2'd1:    w = l_rep;
      2'd2:    w = ~a_ext;
      default: w = {DataWidth{odd}};
    endcase
    return w;
  endfunction

  // Address zero-extended/truncated to the data width; LFSR replicated across the word.
  for (genvar gi = 0; gi < DataWidth; gi++) begin : g_bits
    if (gi < AddrWidth) begin : g_addr
      assign wr_addr_ext[gi]  = addr_reg[gi];
      assign rsp_addr_ext[gi] = rsp_addr_reg[gi];
    end else begin : g_zero
      assign wr_addr_ext[gi]  = 1'b0;
      assign rsp_addr_ext[gi] = 1'b0;
    end
    assign wr_lfsr_rep[gi]  = wr_lfsr_reg[gi % 32];
    assign rsp_lfsr_rep[gi] = rsp_lfsr_reg[gi % 32];
  end

  assign start_acc = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && start_i && !abort_i;
  assign mem_req_o = (state_reg == S_WRITE) ||
                     ((state_reg == S_READ) && (outstanding_reg < OutMax));
  assign mem_we_o    = (state_reg == S_WRITE);
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = mem_we_o ? pattern_word(pattern_reg, wr_addr_ext, wr_lfsr_rep, idx_reg[0])
                                : '0;
  assign mem_be_o    = '1;

  assign gnt_fire  = mem_req_o && mem_gnt_i;
  assign rd_gnt    = gnt_fire && (state_reg == S_READ);
  assign last_word = (idx_reg == num_words_reg - CntWidth'(1));
  // Responses with nothing outstanding are stray and ignored entirely.
  assign rsp_fire  = mem_rvalid_i && (outstanding_reg != '0);
  assign cmp_fire  = rsp_fire && !abort_pend_reg &&
                     ((state_reg == S_READ) || (state_reg == S_DRAIN));
  assign cmp_mismatch = cmp_valid_reg && (cmp_rdata_reg != cmp_exp_reg);

  assign busy_o    = (state_reg == S_INIT) || (state_reg == S_WRITE) || (state_reg == S_READ) ||
                     (state_reg == S_DRAIN) || (state_reg == S_ABORT);
  assign done_o    = (state_reg == S_DONE);
  assign err_cnt_o = err_cnt_reg;

  always_comb begin
    state_next      = state_reg;
    abort_pend_next = abort_pend_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (abort_i)      state_next = S_IDLE;
        else if (start_i) state_next = S_INIT;
      end
      S_INIT: begin
        if (abort_i)                     state_next = S_IDLE;
        else if (num_words_reg == '0)    state_next = S_DONE;
        else if (mode_reg == 2'd2)       state_next = S_READ;
        else                             state_next = S_WRITE;
      end
      S_WRITE, S_READ: begin
        // An abort waits for any request already on the bus to be granted.
        if (abort_i || abort_pend_reg) begin
          if (gnt_fire || !mem_req_o) begin
            state_next      = S_ABORT;
            abort_pend_next = 1'b0;
          end else begin
            abort_pend_next = 1'b1;
          end
        end else if (gnt_fire && last_word) begin
          if (state_reg == S_READ)  state_next = S_DRAIN;
          else if (mode_reg == 2'd1) state_next = S_DONE;
          else                       state_next = S_READ;
        end
      end
      S_DRAIN: begin
        if (abort_i) state_next = S_ABORT;
        else if ((outstanding_reg == '0) && !cmp_valid_reg) state_next = S_DONE;
      end
      S_ABORT: begin
        if (outstanding_reg == '0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg       <= S_IDLE;
      abort_pend_reg  <= 1'b0;
      mode_reg        <= '0;
      pattern_reg     <= '0;
      base_reg        <= '0;
      addr_reg        <= '0;
      rsp_addr_reg    <= '0;
      num_words_reg   <= '0;
      idx_reg         <= '0;
      rsp_odd_reg     <= 1'b0;
      err_cnt_reg     <= '0;
      wr_lfsr_reg     <= SeedInit;
      rsp_lfsr_reg    <= SeedInit;
      outstanding_reg <= '0;
      cmp_valid_reg   <= 1'b0;
      cmp_rdata_reg   <= '0;
      cmp_exp_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      abort_pend_reg <= abort_pend_next;

      if (gnt_fire) begin
        addr_reg <= addr_reg + AddrStep;
        idx_reg  <= idx_reg + CntWidth'(1);
        if (state_reg == S_WRITE) wr_lfsr_reg <= lfsr_step(wr_lfsr_reg);
        if ((state_reg == S_WRITE) && (state_next == S_READ)) begin
          addr_reg <= base_reg;
          idx_reg  <= '0;
        end
      end

      if (rd_gnt && !rsp_fire)      outstanding_reg <= outstanding_reg + OutW'(1);
      else if (!rd_gnt && rsp_fire) outstanding_reg <= outstanding_reg - OutW'(1);

      // Expected data tracks responses, not issue, so it stays aligned with in-order returns.
      cmp_valid_reg <= cmp_fire;
      if (cmp_fire) begin
        cmp_rdata_reg <= mem_rdata_i;
        cmp_exp_reg   <= pattern_word(pattern_reg, rsp_addr_ext, rsp_lfsr_rep, rsp_odd_reg);
        rsp_addr_reg  <= rsp_addr_reg + AddrStep;
        rsp_lfsr_reg  <= lfsr_step(rsp_lfsr_reg);
        rsp_odd_reg   <= ~rsp_odd_reg;
      end

      if (cmp_mismatch && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + CntWidth'(1);

      if (start_acc) begin
        mode_reg       <= mode_i;
        pattern_reg    <= pattern_i;
        base_reg       <= base_addr_i & AlignMask;
        addr_reg       <= base_addr_i & AlignMask;
        rsp_addr_reg   <= base_addr_i & AlignMask;
        num_words_reg  <= num_words_i;
        idx_reg        <= '0;
        rsp_odd_reg    <= 1'b0;
        wr_lfsr_reg    <= SeedInit;
        rsp_lfsr_reg   <= SeedInit;
        err_cnt_reg    <= '0;
        cmp_valid_reg  <= 1'b0;
        abort_pend_reg <= 1'b0;
      end
    end
  end

`ifdef HYPER_MEM_BIST_ERR_LOG_EN
  logic [AddrWidth-1:0] cmp_addr_reg, first_err_addr_reg;
  logic [DataWidth-1:0] first_err_rdata_reg;
  logic                 err_seen_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmp_addr_reg        <= '0;
      first_err_addr_reg  <= '0;
      first_err_rdata_reg <= '0;
      err_seen_reg        <= 1'b0;
    end else if (start_acc) begin
      first_err_addr_reg  <= '0;
      first_err_rdata_reg <= '0;
      err_seen_reg        <= 1'b0;
    end else begin
      if (cmp_fire) cmp_addr_reg <= rsp_addr_reg;
      if (cmp_mismatch && !err_seen_reg) begin
        err_seen_reg        <= 1'b1;
        first_err_addr_reg  <= cmp_addr_reg;
        first_err_rdata_reg <= cmp_rdata_reg;
      end
    end
  end

  assign first_err_addr_o  = first_err_addr_reg;
  assign first_err_rdata_o = first_err_rdata_reg;
`else
  assign first_err_addr_o  = '0;
  assign first_err_rdata_o = '0;
`endif

endmodule

// File: tb/tb_hyper_mem_bist.sv
// Scoreboard bench for hyper_mem_bist: expected memory requests are queued per run and a
// monitor checks each granted request; a behavioural memory answers reads in order.
module tb_hyper_mem_bist;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0;
  logic [1:0]    mode_i = '0, pattern_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] num_words_i = '0;
  logic          busy_o, done_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] first_err_addr_o;
  logic [DW-1:0] first_err_rdata_o;
  logic          mem_req_o, mem_gnt_i, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk = ~clk;

  hyper_mem_bist #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .pattern_i(pattern_i), .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .first_err_rdata_o(first_err_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [1:0] p, input logic [AW-1:0] a,
                                             input logic [31:0] s, input int i);
    case (p)
      2'd0:    return {32'h0, a};
      2'd1:    return {s, s};
      2'd2:    return ~{32'h0, a};
      default: return (i % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
    endcase
  endfunction

  // ---------------- memory model ----------------
  typedef struct { int unsigned due; logic [DW-1:0] data; } rsp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  logic [DW-1:0] mem [logic [AW-1:0]];
  rsp_t rsp_q[$];
  req_t exp_q[$];
  int unsigned cyc = 0;
  int lat = 1;
  int grant_limit = 0;
  int run_grants = 0;
  bit fault_en = 1'b0;
  logic [AW-1:0] fault_addr = '0;

  initial begin
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
      mem_gnt_i = (grant_limit == 0) || (run_grants < grant_limit);
      if (rst_n && mem_req_o && mem_gnt_i) begin
        run_grants++;
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        else begin
          logic [DW-1:0] d;
          d = mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
          if (fault_en && mem_addr_o == fault_addr) d = d ^ 64'h8;
          rsp_q.push_back('{cyc + lat, d});
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int tb_out = 0;
  int max_out = 0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (tb_out == MO) check("req_when_full", {63'h0, mem_req_o}, 64'h0);
        if (mem_req_o && mem_gnt_i) begin
          $display("txn we=%0d addr=%h wdata=%h be=%h", mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_req: got addr %h we %0d, expected none", mem_addr_o, mem_we_o);
          end else begin
            req_t e;
            e = exp_q.pop_front();
            check("req_we", {63'h0, mem_we_o}, {63'h0, e.we});
            check("req_addr", {32'h0, mem_addr_o}, {32'h0, e.addr});
            if (e.we) check("req_wdata", mem_wdata_o, e.data);
          end
          if (!mem_we_o) tb_out++;
        end
        if (mem_rvalid_i && tb_out > 0) tb_out--;
        if (tb_out > max_out) max_out = tb_out;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_run(input logic [1:0] m, input logic [1:0] p, input logic [AW-1:0] b,
                          input int n);
    logic [AW-1:0] a;
    logic [31:0] s;
    if (m != 2'd2) begin
      a = b; s = 32'h0000_ACE1;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{1'b1, a, exp_word(p, a, s, i)});
        a = a + 32'd8; s = lfsr_next(s);
      end
    end
    if (m != 2'd1) begin
      a = b;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{1'b0, a, '0});
        a = a + 32'd8;
      end
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [1:0] p, input logic [AW-1:0] b,
                           input logic [CW-1:0] n);
    run_grants = 0;
    mode_i = m; pattern_i = p; base_addr_i = b; num_words_i = n;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {63'h0, done_o}, 64'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] s4;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'h0, busy_o}, 64'h0);
    check("rst_done", {63'h0, done_o}, 64'h0);
    check("rst_req", {63'h0, mem_req_o}, 64'h0);
    check("rst_err", {48'h0, err_cnt_o}, 64'h0);
    check("rst_first_addr", {32'h0, first_err_addr_o}, 64'h0);
    check("rst_first_rdata", first_err_rdata_o, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 pattern 0, plus a start pulse mid-run that must be ignored
    lat = 1;
    push_run(2'd0, 2'd0, 32'h8000_0000, 16);
    start_run(2'd0, 2'd0, 32'h8000_0000, 16);
    repeat (5) @(negedge clk);
    mode_i = 2'd1; base_addr_i = 32'h1234_0000; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("t1_done", 300);
    check("t1_err", {48'h0, err_cnt_o}, 64'h0);
    check("t1_busy", {63'h0, busy_o}, 64'h0);
    check("t1_queue", 64'(exp_q.size()), 64'h0);

    // Mode 0 pattern 1 with one corrupted read
    fault_en = 1'b1; fault_addr = 32'h8000_0020;
    push_run(2'd0, 2'd1, 32'h8000_0000, 16);
    start_run(2'd0, 2'd1, 32'h8000_0000, 16);
    wait_done("t2_done", 300);
    fault_en = 1'b0;
    check("t2_err", {48'h0, err_cnt_o}, 64'h1);
    s4 = 32'h0000_ACE1;
    for (int i = 0; i < 4; i++) s4 = lfsr_next(s4);
`ifdef HYPER_MEM_BIST_ERR_LOG_EN
    check("t2_first_addr", {32'h0, first_err_addr_o}, 64'h8000_0020);
    check("t2_first_rdata", first_err_rdata_o, {s4, s4} ^ 64'h8);
`else
    check("t2_first_addr", {32'h0, first_err_addr_o}, 64'h0);
    check("t2_first_rdata", first_err_rdata_o, 64'h0);
`endif
    check("t2_queue", 64'(exp_q.size()), 64'h0);

    // Read-only with slow responses: outstanding capped at MaxOutstanding
    lat = 10; max_out = 0;
    push_run(2'd2, 2'd1, 32'h8000_0000, 16);
    start_run(2'd2, 2'd1, 32'h8000_0000, 16);
    wait_done("t3_done", 500);
    check("t3_err", {48'h0, err_cnt_o}, 64'h0);
    check("t3_max_out", 64'(max_out), 64'(MO));
    check("t3_queue", 64'(exp_q.size()), 64'h0);

    // Zero words: done exactly two cycles after start, no traffic
    lat = 1;
    start_run(2'd0, 2'd0, 32'h0000_4000, 16'd0);
    check("t4_done_c1", {63'h0, done_o}, 64'h0);
    @(negedge clk);
    check("t4_done_c2", {63'h0, done_o}, 64'h1);
    check("t4_grants", 64'(run_grants), 64'h0);

    // Address wrap, write-only checkerboard
    push_run(2'd1, 2'd3, 32'hFFFF_FFF8, 3);
    start_run(2'd1, 2'd3, 32'hFFFF_FFF8, 16'd3);
    wait_done("t5_done", 100);
    check("t5_queue", 64'(exp_q.size()), 64'h0);

    // Abort during READ with a pending ungranted request
    lat = 20; grant_limit = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 32'h1000 + 32'(8 * i), '0});
    start_run(2'd2, 2'd0, 32'h0000_1000, 16'd8);
    for (int k = 0; k < 100 && run_grants < 3; k++) @(negedge clk);
    check("t6_grants3", 64'(run_grants), 64'h3);
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t6_busy_abort", {63'h0, busy_o}, 64'h1);
    repeat (3) @(negedge clk);
    grant_limit = 0;
    for (int k = 0; k < 200 && busy_o; k++) @(negedge clk);
    check("t6_busy", {63'h0, busy_o}, 64'h0);
    check("t6_done", {63'h0, done_o}, 64'h0);
    check("t6_err", {48'h0, err_cnt_o}, 64'h0);
    check("t6_grants4", 64'(run_grants), 64'h4);
    check("t6_rsp_drained", 64'(rsp_q.size()), 64'h0);
    check("t6_queue", 64'(exp_q.size()), 64'h0);

    // Fresh run after abort, then abort in DONE clears done
    lat = 1;
    push_run(2'd0, 2'd2, 32'h0000_1000, 8);
    start_run(2'd0, 2'd2, 32'h0000_1000, 16'd8);
    wait_done("t7_done", 200);
    check("t7_err", {48'h0, err_cnt_o}, 64'h0);
    check("t7_queue", 64'(exp_q.size()), 64'h0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("t7_abort_done", {63'h0, done_o}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
